processor_mc_core: RTL and testbench
====================================

PROCESSOR_MC_CORE -- requirements
Module: processor_mc_core

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH_t, default 64, meaning the register, ALU and data-bus width.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH_t, default 32, meaning the PC and memory-address width.
REQ-003 The block SHALL have parameter PC_RESET_t, default 0, meaning the PC value loaded on reset.
REQ-004 The block SHALL have parameter NumRegs_t, default 32, meaning the register count; index width is $clog2(NumRegs_t).
REQ-005 The block SHALL have port clk_t, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-006 The block SHALL have port rst_t, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have ports imem_req (out, 1), imem_addr (out, ADDRESS_WIDTH_t), imem_ready (in, 1) and imem_rdata (in, 32), forming the instruction fetch handshake.
REQ-008 The block SHALL have ports dmem_req (out, 1), dmem_we (out, 1), dmem_addr (out, ADDRESS_WIDTH_t), dmem_wdata (out, DATA_WIDTH_t), dmem_ready (in, 1) and dmem_rdata (in, DATA_WIDTH_t), forming the data access handshake.
REQ-009 The block SHALL have port ALU_O_t, out, DATA_WIDTH_t: the registered ALU result.
REQ-010 The block SHALL have port read_data_o_t, out, DATA_WIDTH_t: the last data latched from a load.
REQ-011 The block SHALL have port halt_o, out, 1 bit: the core is in HALT.
REQ-012 The block SHALL have port instret_o, out, 32 bits: the retired-instruction count.

Function
REQ-013 The block SHALL be a multicycle RV64I-subset core with an internal NumRegs_t x DATA_WIDTH_t register file in which x0 reads as 0 and ignores writes.
REQ-014 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-015 FETCH: hold imem_req=1 and imem_addr=PC until imem_ready=1 is sampled; on that edge latch imem_rdata into IR and go to DECODE.
REQ-016 DECODE: latch A=rs1, B=rs2 and the sign-extended immediate (I, S or B format, with the B immediate bit0=0); go to EXEC.
REQ-017 Supported opcodes SHALL be:
- R 0110011: add, sub, and, or.
- I 0010011: addi, andi, ori.
- Load 0000011: funct3 011 (ld).
- Store 0100011: funct3 011 (sd).
- Branch 1100011: beq, bne.
REQ-018 Any other opcode/funct3 combination, including 1110011, SHALL move EXEC to HALT without modifying the PC or any register.
REQ-019 EXEC, R/I: register the ALU result into ALU_O_t and go to WB.
REQ-020 EXEC, ld/sd: register ALU_O_t = A+imm and go to MEM.
REQ-021 EXEC, branch: compute A-B; if taken, PC <= PC+imm, otherwise PC <= PC+4; increment instret_o; go to FETCH.
REQ-022 MEM: hold dmem_req=1, dmem_addr=ALU_O_t[ADDRESS_WIDTH_t-1:0], dmem_we=1 for sd, and dmem_wdata=B until dmem_ready=1 is sampled.
REQ-023 On MEM completion, ld SHALL latch dmem_rdata into read_data_o_t and go to WB.
REQ-024 On MEM completion, sd SHALL set PC <= PC+4, increment instret_o and go to FETCH.
REQ-025 WB: write the result (read_data_o_t for ld, ALU_O_t otherwise) to rd unless rd=0; set PC <= PC+4; increment instret_o; go to FETCH.
REQ-026 Arithmetic SHALL wrap modulo 2^DATA_WIDTH_t, and PC arithmetic SHALL wrap modulo 2^ADDRESS_WIDTH_t.
REQ-027 With zero-wait memories (ready=1 combinationally), latency in clocks SHALL be: branch 3, R/I 4, sd 4, ld 5; each wait cycle adds exactly one clock.
REQ-028 imem_req and dmem_req SHALL be 0 in every state other than FETCH and MEM respectively.
REQ-029 Addresses and data SHALL be stable while the corresponding req=1.
REQ-030 HALT SHALL be absorbing until reset: no requests issued, halt_o=1, and no register or PC change.
REQ-031 instret_o SHALL wrap from 2^32-1 to 0.

Reset
REQ-032 On rst_t=0, regardless of clk_t, the block SHALL immediately set state=FETCH, PC=PC_RESET_t, IR=0, ALU_O_t=0, read_data_o_t=0, instret_o=0, halt_o=0 and all registers to 0.
REQ-033 Any request in flight when reset asserts SHALL be abandoned, with imem_req and dmem_req driven to 0 while rst_t=0.
REQ-034 The first FETCH after rst_t deasserts SHALL request address PC_RESET_t.

Verification
REQ-035 Program `addi x1,x0,5`; `addi x2,x0,-3`; `add x3,x1,x2` with zero-wait memories -> x3=2, ALU_O_t=2, instret_o=3 after 12 clocks.
REQ-036 `sd x3,8(x0)` then `ld x4,8(x0)`, with dmem_ready held low for 2 cycles on each access -> the write sees wdata=2 at addr=8, x4=2, the load takes 7 clocks, and req is stable throughout each wait.
REQ-037 `beq x0,x0,-8` at PC 0x10 -> next imem_addr=0x08 after 3 clocks; `bne x0,x0,+8` -> next imem_addr=PC+4.
REQ-038 `addi x0,x0,7` followed by `add x5,x0,x0` -> x5=0.
REQ-039 Opcode 0x7F -> halt_o=1 and no further imem_req; a subsequent rst_t pulse -> fetch restarts at PC_RESET_t.
REQ-040 rst_t asserted mid-MEM with dmem_req=1 -> dmem_req=0 asynchronously, all outputs return to their reset values, and no register is written.

Source files
------------

// File: rtl/processor_mc_core.sv
// Multicycle RV64I-subset core (add/sub/and/or, addi/andi/ori, ld, sd, beq, bne)
// built around a FETCH/DECODE/EXEC/MEM/WB state machine with req/ready memory ports.
module processor_mc_core #(
    parameter int unsigned                DATA_WIDTH_t    = 64,
    parameter int unsigned                ADDRESS_WIDTH_t = 32,
    parameter logic [ADDRESS_WIDTH_t-1:0] PC_RESET_t      = '0,
    parameter int unsigned                NumRegs_t       = 32
) (
    input  logic                       clk_t,
    input  logic                       rst_t,
    // instruction fetch port
    output logic                       imem_req,
    output logic [ADDRESS_WIDTH_t-1:0] imem_addr,
    input  logic                       imem_ready,
    input  logic [31:0]                imem_rdata,
    // data access port
    output logic                       dmem_req,
    output logic                       dmem_we,
    output logic [ADDRESS_WIDTH_t-1:0] dmem_addr,
    output logic [DATA_WIDTH_t-1:0]    dmem_wdata,
    input  logic                       dmem_ready,
    input  logic [DATA_WIDTH_t-1:0]    dmem_rdata,
    // status
    output logic [DATA_WIDTH_t-1:0]    ALU_O_t,
    output logic [DATA_WIDTH_t-1:0]    read_data_o_t,
    output logic                       halt_o,
    output logic [31:0]                instret_o
);

    localparam int unsigned RegIdxW = (NumRegs_t > 1) ? $clog2(NumRegs_t) : 1;
    localparam int unsigned InstrW  = 32;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam logic [2:0] F3Add = 3'b000;
    localparam logic [2:0] F3Or  = 3'b110;
    localparam logic [2:0] F3And = 3'b111;
    localparam logic [2:0] F3D   = 3'b011;
    localparam logic [2:0] F3Beq = 3'b000;
    localparam logic [2:0] F3Bne = 3'b001;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Sub  = 7'b0100000;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;

    state_e                     state_q, state_d;
    logic [ADDRESS_WIDTH_t-1:0] pc_q, pc_d;
    logic [InstrW-1:0]          ir_q, ir_d;
    logic [DATA_WIDTH_t-1:0]    a_q, a_d;
    logic [DATA_WIDTH_t-1:0]    b_q, b_d;
    logic [DATA_WIDTH_t-1:0]    imm_q, imm_d;
    logic [DATA_WIDTH_t-1:0]    alu_q, alu_d;
    logic [DATA_WIDTH_t-1:0]    rdata_q, rdata_d;
    logic [31:0]                instret_q, instret_d;

    logic [DATA_WIDTH_t-1:0]    rf_q [NumRegs_t];
    logic                       rf_we;
    logic [RegIdxW-1:0]         rf_waddr;
    logic [DATA_WIDTH_t-1:0]    rf_wdata;

    // instruction fields
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [RegIdxW-1:0] rd_idx, rs1_idx, rs2_idx;
    logic [11:0]        imm_i12, imm_s12;
    logic [12:0]        imm_b13;

    logic is_r, is_i, is_ld, is_sd, is_br, sub_op;

    logic [DATA_WIDTH_t-1:0]    alu_b, alu_res;
    logic                       br_eq, br_taken;
    logic [ADDRESS_WIDTH_t-1:0] pc_plus4, pc_plus_imm;

    // Field extraction and legality decode of the latched instruction
    always_comb begin
        opcode  = ir_q[6:0];
        funct3  = ir_q[14:12];
        funct7  = ir_q[31:25];
        rd_idx  = RegIdxW'(ir_q[11:7]);
        rs1_idx = RegIdxW'(ir_q[19:15]);
        rs2_idx = RegIdxW'(ir_q[24:20]);
        imm_i12 = ir_q[31:20];
        imm_s12 = {ir_q[31:25], ir_q[11:7]};
        imm_b13 = {ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

        is_r   = (opcode == OpR) &&
                 (((funct7 == F7Base) && ((funct3 == F3Add) || (funct3 == F3And) || (funct3 == F3Or))) ||
                  ((funct7 == F7Sub) && (funct3 == F3Add)));
        is_i   = (opcode == OpImm) &&
                 ((funct3 == F3Add) || (funct3 == F3And) || (funct3 == F3Or));
        is_ld  = (opcode == OpLoad) && (funct3 == F3D);
        is_sd  = (opcode == OpStore) && (funct3 == F3D);
        is_br  = (opcode == OpBranch) && ((funct3 == F3Beq) || (funct3 == F3Bne));
        sub_op = is_r && (funct7 == F7Sub);
    end

    // ALU: R-type uses B, everything else (incl. ld/sd address) uses the immediate
    always_comb begin
        alu_b   = is_r ? b_q : imm_q;
        alu_res = '0;
        case (funct3)
            F3And:   alu_res = a_q & alu_b;
            F3Or:    alu_res = a_q | alu_b;
            default: alu_res = sub_op ? (a_q - alu_b) : (a_q + alu_b);
        endcase
    end

    // Branch compare and PC arithmetic (wraps at ADDRESS_WIDTH_t)
    always_comb begin
        br_eq       = ((a_q - b_q) == '0);
        br_taken    = funct3[0] ? ~br_eq : br_eq;
        pc_plus4    = pc_q + ADDRESS_WIDTH_t'(4);
        pc_plus_imm = pc_q + ADDRESS_WIDTH_t'(imm_q);
    end

    // State register and datapath registers
    always_ff @(posedge clk_t or negedge rst_t) begin
        if (!rst_t) begin
            state_q   <= FETCH;
            pc_q      <= PC_RESET_t;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            alu_q     <= '0;
            rdata_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            alu_q     <= alu_d;
            rdata_q   <= rdata_d;
            instret_q <= instret_d;
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        alu_d     = alu_q;
        rdata_d   = rdata_q;
        instret_d = instret_q;
        rf_we     = 1'b0;
        rf_waddr  = rd_idx;
        rf_wdata  = is_ld ? rdata_q : alu_q;

        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d = rf_q[rs1_idx];
                b_d = rf_q[rs2_idx];
                if (opcode == OpStore) begin
                    imm_d = DATA_WIDTH_t'($signed(imm_s12));
                end else if (opcode == OpBranch) begin
                    imm_d = DATA_WIDTH_t'($signed(imm_b13));
                end else begin
                    imm_d = DATA_WIDTH_t'($signed(imm_i12));
                end
                state_d = EXEC;
            end
            EXEC: begin
                if (is_r || is_i) begin
                    alu_d   = alu_res;
                    state_d = WB;
                end else if (is_ld || is_sd) begin
                    alu_d   = alu_res;
                    state_d = MEM;
                end else if (is_br) begin
                    pc_d      = br_taken ? pc_plus_imm : pc_plus4;
                    instret_d = instret_q + 32'd1;
                    state_d   = FETCH;
                end else begin
                    // unsupported encoding: stop with PC and registers untouched
                    state_d = HALT;
                end
            end
            MEM: begin
                if (dmem_ready) begin
                    if (is_ld) begin
                        rdata_d = dmem_rdata;
                        state_d = WB;
                    end else begin
                        pc_d      = pc_plus4;
                        instret_d = instret_q + 32'd1;
                        state_d   = FETCH;
                    end
                end
            end
            WB: begin
                rf_we     = (rd_idx != '0);
                pc_d      = pc_plus4;
                instret_d = instret_q + 32'd1;
                state_d   = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    // Register file; x0 is never written so it always reads zero
    always_ff @(posedge clk_t or negedge rst_t) begin
        if (!rst_t) begin
            for (int unsigned i = 0; i < NumRegs_t; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    // Requests are gated by reset so an in-flight access drops immediately
    always_comb begin
        imem_req      = rst_t && (state_q == FETCH);
        imem_addr     = pc_q;
        dmem_req      = rst_t && (state_q == MEM);
        dmem_we       = dmem_req && is_sd;
        dmem_addr     = alu_q[ADDRESS_WIDTH_t-1:0];
        dmem_wdata    = b_q;
        ALU_O_t       = alu_q;
        read_data_o_t = rdata_q;
        halt_o        = (state_q == HALT);
        instret_o     = instret_q;
    end

endmodule

// File: tb/tb_processor_mc_core.sv
// Directed bench for processor_mc_core with wait-state capable memory models.
module tb_processor_mc_core;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 32;
    localparam logic [6:0]  OPI = 7'b0010011;
    localparam logic [6:0]  OPL = 7'b0000011;

    logic          clk_t = 1'b0;
    logic          rst_t = 1'b0;
    logic          imem_req, imem_ready;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          dmem_req, dmem_we, dmem_ready;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata, dmem_rdata;
    logic [DW-1:0] ALU_O_t, read_data_o_t;
    logic          halt_o;
    logic [31:0]   instret_o;

    processor_mc_core dut (
        .clk_t(clk_t), .rst_t(rst_t),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .ALU_O_t(ALU_O_t), .read_data_o_t(read_data_o_t), .halt_o(halt_o), .instret_o(instret_o)
    );

    always #5 clk_t = ~clk_t;

    // memory models
    logic [31:0]   imem [64];
    logic [DW-1:0] dmem [16];
    logic [DW-1:0] dmem_init [16];
    int unsigned   iwait = 0, dwait = 0;
    int unsigned   icnt = 0, dcnt = 0;
    logic          ipend = 1'b0, dpend = 1'b0;
    logic [AW-1:0] isav_addr = '0, dsav_addr = '0;
    logic [DW-1:0] dsav_wdata = '0;
    logic          dsav_we = 1'b0;
    int unsigned   ireq_cycles = 0, dreq_cycles = 0, stab_err = 0, wr_count = 0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    assign imem_ready = (icnt >= iwait);
    assign dmem_ready = dmem_req && (dcnt >= dwait);
    assign imem_rdata = imem[imem_addr[7:2]];
    assign dmem_rdata = dmem[dmem_addr[6:3]];

    // wait-state generation, data writes and request stability tracking
    always @(posedge clk_t or negedge rst_t) begin
        if (!rst_t) begin
            icnt  <= 0;
            dcnt  <= 0;
            ipend <= 1'b0;
            dpend <= 1'b0;
            for (int i = 0; i < 16; i++) dmem[i] <= dmem_init[i];
        end else begin
            if (imem_req) begin
                ireq_cycles <= ireq_cycles + 1;
                if (ipend && (imem_addr !== isav_addr)) stab_err <= stab_err + 1;
                if (imem_ready) begin
                    icnt <= 0; ipend <= 1'b0;
                end else begin
                    icnt <= icnt + 1; ipend <= 1'b1; isav_addr <= imem_addr;
                end
            end
            if (dmem_req) begin
                dreq_cycles <= dreq_cycles + 1;
                if (dpend && ((dmem_addr !== dsav_addr) || (dmem_wdata !== dsav_wdata) || (dmem_we !== dsav_we)))
                    stab_err <= stab_err + 1;
                if (dmem_ready) begin
                    dcnt <= 0; dpend <= 1'b0;
                    if (dmem_we) begin
                        dmem[dmem_addr[6:3]] <= dmem_wdata;
                        wr_count <= wr_count + 1;
                        wr_addr  <= dmem_addr;
                        wr_data  <= dmem_wdata;
                    end
                end else begin
                    dcnt <= dcnt + 1; dpend <= 1'b1;
                    dsav_addr <= dmem_addr; dsav_wdata <= dmem_wdata; dsav_we <= dmem_we;
                end
            end
        end
    end

    // instruction encoders
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_t);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0000007F;
        for (int i = 0; i < 16; i++) dmem_init[i] = '0;
    endtask

    task automatic reset_core();
        rst_t = 1'b0;
        tick(2);
        rst_t = 1'b1;
    endtask

    task automatic test_reset();
        clear_mem();
        imem[0] = enc_i(12'h000, 5'd0, 3'b000, 5'd0, OPI);
        rst_t = 1'b0;
        tick(2);
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_imem_req: got %b exp 0", imem_req); end
        n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_dmem_req: got %b exp 0", dmem_req); end
        n_checks++; if (halt_o !== 1'b0) begin n_fail++; $display("FAIL rst_halt: got %b exp 0", halt_o); end
        n_checks++; if (instret_o !== 32'd0) begin n_fail++; $display("FAIL rst_instret: got %0d exp 0", instret_o); end
        n_checks++; if (ALU_O_t !== 64'd0) begin n_fail++; $display("FAIL rst_alu: got %0h exp 0", ALU_O_t); end
        n_checks++; if (read_data_o_t !== 64'd0) begin n_fail++; $display("FAIL rst_rdata: got %0h exp 0", read_data_o_t); end
        rst_t = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_fetch_req: got %b exp 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_fetch_addr: got %0h exp 0", imem_addr); end
        tick(1);
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL decode_imem_req: got %b exp 0", imem_req); end
    endtask

    task automatic test_alu();
        clear_mem();
        imem[0]  = enc_i(12'h005, 5'd0, 3'b000, 5'd1, OPI);   // addi x1,x0,5
        imem[1]  = enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, OPI);   // addi x2,x0,-3
        imem[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);    // add  x3,x1,x2
        imem[3]  = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd6);    // sub  x6,x1,x2
        imem[4]  = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd7);    // and  x7,x1,x2
        imem[5]  = enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd8);    // or   x8,x1,x2
        imem[6]  = enc_i(12'h0F0, 5'd2, 3'b111, 5'd9, OPI);   // andi x9,x2,0xF0
        imem[7]  = enc_i(12'h7FF, 5'd0, 3'b110, 5'd10, OPI);  // ori  x10,x0,0x7FF
        imem[8]  = enc_i(12'hFFF, 5'd0, 3'b000, 5'd13, OPI);  // addi x13,x0,-1
        imem[9]  = enc_i(12'h001, 5'd13, 3'b000, 5'd14, OPI); // addi x14,x13,1
        imem[10] = enc_i(12'h007, 5'd0, 3'b000, 5'd0, OPI);   // addi x0,x0,7
        imem[11] = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd5);    // add  x5,x0,x0
        reset_core();
        tick(11);
        n_checks++; if (instret_o !== 32'd2) begin n_fail++; $display("FAIL alu_instret_11clk: got %0d exp 2", instret_o); end
        tick(1);
        n_checks++; if (instret_o !== 32'd3) begin n_fail++; $display("FAIL alu_instret_12clk: got %0d exp 3", instret_o); end
        n_checks++; if (ALU_O_t !== 64'd2) begin n_fail++; $display("FAIL alu_out_x3: got %0h exp 2", ALU_O_t); end
        n_checks++; if (dut.rf_q[3] !== 64'd2) begin n_fail++; $display("FAIL alu_x3: got %0h exp 2", dut.rf_q[3]); end
        n_checks++; if (imem_addr !== 32'h0C) begin n_fail++; $display("FAIL alu_pc_12clk: got %0h exp c", imem_addr); end
        tick(36);
        n_checks++; if (instret_o !== 32'd12) begin n_fail++; $display("FAIL alu_instret_48clk: got %0d exp 12", instret_o); end
        n_checks++; if (dut.rf_q[6] !== 64'd8) begin n_fail++; $display("FAIL alu_sub: got %0h exp 8", dut.rf_q[6]); end
        n_checks++; if (dut.rf_q[7] !== 64'd5) begin n_fail++; $display("FAIL alu_and: got %0h exp 5", dut.rf_q[7]); end
        n_checks++; if (dut.rf_q[8] !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL alu_or: got %0h exp fffffffffffffffd", dut.rf_q[8]); end
        n_checks++; if (dut.rf_q[9] !== 64'hF0) begin n_fail++; $display("FAIL alu_andi: got %0h exp f0", dut.rf_q[9]); end
        n_checks++; if (dut.rf_q[10] !== 64'h7FF) begin n_fail++; $display("FAIL alu_ori: got %0h exp 7ff", dut.rf_q[10]); end
        n_checks++; if (dut.rf_q[14] !== 64'd0) begin n_fail++; $display("FAIL alu_wrap: got %0h exp 0", dut.rf_q[14]); end
        n_checks++; if (dut.rf_q[0] !== 64'd0) begin n_fail++; $display("FAIL x0_zero: got %0h exp 0", dut.rf_q[0]); end
        n_checks++; if (dut.rf_q[5] !== 64'd0) begin n_fail++; $display("FAIL x5_from_x0: got %0h exp 0", dut.rf_q[5]); end
        tick(2);
        n_checks++; if (halt_o !== 1'b0) begin n_fail++; $display("FAIL halt_early: got %b exp 0", halt_o); end
        tick(1);
        n_checks++; if (halt_o !== 1'b1) begin n_fail++; $display("FAIL halt_set: got %b exp 1", halt_o); end
        begin
            int unsigned ireq0;
            ireq0 = ireq_cycles;
            tick(10);
            n_checks++; if (ireq_cycles - ireq0 !== 0) begin n_fail++; $display("FAIL halt_no_fetch: got %0d req cycles exp 0", ireq_cycles - ireq0); end
        end
        n_checks++; if (imem_addr !== 32'h30) begin n_fail++; $display("FAIL halt_pc: got %0h exp 30", imem_addr); end
        n_checks++; if (instret_o !== 32'd12) begin n_fail++; $display("FAIL halt_instret: got %0d exp 12", instret_o); end
    endtask

    task automatic test_mem();
        int unsigned d0, w0, s0;
        clear_mem();
        dmem_init[1] = 64'hDEAD;
        imem[0] = enc_i(12'h002, 5'd0, 3'b000, 5'd3, OPI);   // addi x3,x0,2
        imem[1] = enc_s(12'h008, 5'd3, 5'd0, 3'b011);        // sd   x3,8(x0)
        imem[2] = enc_i(12'h008, 5'd0, 3'b011, 5'd4, OPL);   // ld   x4,8(x0)
        dwait = 2;
        reset_core();
        d0 = dreq_cycles; w0 = wr_count; s0 = stab_err;
        tick(7);
        n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL sd_req: got %b exp 1", dmem_req); end
        n_checks++; if (dmem_we !== 1'b1) begin n_fail++; $display("FAIL sd_we: got %b exp 1", dmem_we); end
        n_checks++; if (dmem_addr !== 32'h8) begin n_fail++; $display("FAIL sd_addr: got %0h exp 8", dmem_addr); end
        n_checks++; if (dmem_wdata !== 64'd2) begin n_fail++; $display("FAIL sd_wdata: got %0h exp 2", dmem_wdata); end
        tick(2);
        n_checks++; if (instret_o !== 32'd1) begin n_fail++; $display("FAIL sd_wait_instret: got %0d exp 1", instret_o); end
        tick(1);
        n_checks++; if (instret_o !== 32'd2) begin n_fail++; $display("FAIL sd_done_instret: got %0d exp 2", instret_o); end
        n_checks++; if (wr_count - w0 !== 1) begin n_fail++; $display("FAIL sd_writes: got %0d exp 1", wr_count - w0); end
        n_checks++; if (wr_addr !== 32'h8 || wr_data !== 64'd2) begin n_fail++; $display("FAIL sd_wr_seen: got addr %0h data %0h exp 8/2", wr_addr, wr_data); end
        tick(3);
        n_checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin n_fail++; $display("FAIL ld_req: got req %b we %b exp 1/0", dmem_req, dmem_we); end
        tick(3);
        n_checks++; if (instret_o !== 32'd2) begin n_fail++; $display("FAIL ld_6clk_instret: got %0d exp 2", instret_o); end
        n_checks++; if (read_data_o_t !== 64'd2) begin n_fail++; $display("FAIL ld_rdata: got %0h exp 2", read_data_o_t); end
        tick(1);
        n_checks++; if (instret_o !== 32'd3) begin n_fail++; $display("FAIL ld_7clk_instret: got %0d exp 3", instret_o); end
        n_checks++; if (dut.rf_q[4] !== 64'd2) begin n_fail++; $display("FAIL ld_x4: got %0h exp 2", dut.rf_q[4]); end
        n_checks++; if (ALU_O_t !== 64'd8) begin n_fail++; $display("FAIL ld_alu_addr: got %0h exp 8", ALU_O_t); end
        n_checks++; if (dreq_cycles - d0 !== 6) begin n_fail++; $display("FAIL mem_req_cycles: got %0d exp 6", dreq_cycles - d0); end
        n_checks++; if (stab_err - s0 !== 0) begin n_fail++; $display("FAIL mem_req_stable: got %0d changes exp 0", stab_err - s0); end
        dwait = 0;
    endtask

    task automatic test_branch();
        int unsigned d0;
        clear_mem();
        imem[0] = enc_i(12'h001, 5'd0, 3'b000, 5'd1, OPI);   // 0x00 addi x1,x0,1
        imem[1] = enc_b(13'h000C, 5'd0, 5'd1, 3'b001);       // 0x04 bne x1,x0,+12 (taken)
        imem[4] = enc_b(13'h1FF8, 5'd0, 5'd0, 3'b000);       // 0x10 beq x0,x0,-8 (taken)
        imem[2] = enc_b(13'h0008, 5'd0, 5'd0, 3'b001);       // 0x08 bne x0,x0,+8 (not taken)
        imem[3] = enc_b(13'h0064, 5'd0, 5'd1, 3'b000);       // 0x0C beq x1,x0,+100 (not taken)
        reset_core();
        d0 = dreq_cycles;
        tick(4);
        n_checks++; if (imem_addr !== 32'h04) begin n_fail++; $display("FAIL br_pc4: got %0h exp 4", imem_addr); end
        tick(3);
        n_checks++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL bne_taken: got %0h exp 10", imem_addr); end
        tick(2);
        n_checks++; if (imem_addr !== 32'h10 || instret_o !== 32'd2) begin n_fail++; $display("FAIL beq_2clk: got pc %0h ir %0d exp 10/2", imem_addr, instret_o); end
        tick(1);
        n_checks++; if (imem_addr !== 32'h08) begin n_fail++; $display("FAIL beq_back: got %0h exp 8", imem_addr); end
        n_checks++; if (instret_o !== 32'd3) begin n_fail++; $display("FAIL beq_instret: got %0d exp 3", instret_o); end
        tick(3);
        n_checks++; if (imem_addr !== 32'h0C) begin n_fail++; $display("FAIL bne_not_taken: got %0h exp c", imem_addr); end
        tick(3);
        n_checks++; if (imem_addr !== 32'h10) begin n_fail++; $display("FAIL beq_not_taken: got %0h exp 10", imem_addr); end
        n_checks++; if (instret_o !== 32'd5) begin n_fail++; $display("FAIL br_instret: got %0d exp 5", instret_o); end
        n_checks++; if (dreq_cycles - d0 !== 0) begin n_fail++; $display("FAIL br_no_dmem: got %0d exp 0", dreq_cycles - d0); end
    endtask

    task automatic test_illegal();
        int unsigned s0, i0;
        clear_mem();
        imem[0] = enc_i(12'h009, 5'd0, 3'b000, 5'd1, OPI);   // addi x1,x0,9
        imem[1] = enc_i(12'h000, 5'd0, 3'b010, 5'd2, OPL);   // lw (unsupported)
        imem[2] = enc_i(12'h001, 5'd0, 3'b000, 5'd3, OPI);
        iwait = 3;
        reset_core();
        s0 = stab_err;
        tick(6);
        n_checks++; if (instret_o !== 32'd0) begin n_fail++; $display("FAIL iwait_6clk: got %0d exp 0", instret_o); end
        tick(1);
        n_checks++; if (instret_o !== 32'd1) begin n_fail++; $display("FAIL iwait_7clk: got %0d exp 1", instret_o); end
        tick(5);
        n_checks++; if (halt_o !== 1'b0) begin n_fail++; $display("FAIL illegal_early: got %b exp 0", halt_o); end
        tick(1);
        n_checks++; if (halt_o !== 1'b1) begin n_fail++; $display("FAIL illegal_halt: got %b exp 1", halt_o); end
        n_checks++; if (imem_addr !== 32'h04) begin n_fail++; $display("FAIL illegal_pc: got %0h exp 4", imem_addr); end
        n_checks++; if (dut.rf_q[1] !== 64'd9 || dut.rf_q[2] !== 64'd0) begin n_fail++; $display("FAIL illegal_regs: got x1 %0h x2 %0h exp 9/0", dut.rf_q[1], dut.rf_q[2]); end
        n_checks++; if (stab_err - s0 !== 0) begin n_fail++; $display("FAIL imem_stable: got %0d changes exp 0", stab_err - s0); end
        i0 = ireq_cycles;
        tick(5);
        n_checks++; if (ireq_cycles - i0 !== 0 || instret_o !== 32'd1) begin n_fail++; $display("FAIL illegal_absorb: got req %0d ir %0d exp 0/1", ireq_cycles - i0, instret_o); end
        // restart after reset, now hitting an ecall
        iwait = 0;
        imem[1] = 32'h00000073;
        reset_core();
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL restart_fetch: got req %b addr %0h exp 1/0", imem_req, imem_addr); end
        tick(4);
        n_checks++; if (instret_o !== 32'd1 || dut.rf_q[1] !== 64'd9) begin n_fail++; $display("FAIL restart_exec: got ir %0d x1 %0h exp 1/9", instret_o, dut.rf_q[1]); end
        tick(3);
        n_checks++; if (halt_o !== 1'b1 || imem_addr !== 32'h04) begin n_fail++; $display("FAIL ecall_halt: got halt %b pc %0h exp 1/4", halt_o, imem_addr); end
    endtask

    task automatic test_reset_mid_mem();
        clear_mem();
        dmem_init[0] = 64'h1234;
        imem[0] = enc_i(12'h007, 5'd0, 3'b000, 5'd1, OPI);   // addi x1,x0,7
        imem[1] = enc_i(12'h000, 5'd0, 3'b011, 5'd2, OPL);   // ld x2,0(x0)
        dwait = 10;
        reset_core();
        tick(7);
        n_checks++; if (dmem_req !== 1'b1 || dut.rf_q[1] !== 64'd7) begin n_fail++; $display("FAIL midmem_setup: got req %b x1 %0h exp 1/7", dmem_req, dut.rf_q[1]); end
        #2;
        rst_t = 1'b0;
        #1;
        n_checks++; if (dmem_req !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL midmem_req_drop: got d %b i %b exp 0/0", dmem_req, imem_req); end
        n_checks++; if (instret_o !== 32'd0 || halt_o !== 1'b0) begin n_fail++; $display("FAIL midmem_status: got ir %0d halt %b exp 0/0", instret_o, halt_o); end
        n_checks++; if (ALU_O_t !== 64'd0 || read_data_o_t !== 64'd0) begin n_fail++; $display("FAIL midmem_data: got alu %0h rd %0h exp 0/0", ALU_O_t, read_data_o_t); end
        n_checks++; if (dut.rf_q[1] !== 64'd0 || dut.rf_q[2] !== 64'd0) begin n_fail++; $display("FAIL midmem_regs: got x1 %0h x2 %0h exp 0/0", dut.rf_q[1], dut.rf_q[2]); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL midmem_pc: got %0h exp 0", imem_addr); end
        dwait = 0;
        tick(2);
        rst_t = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL midmem_refetch: got req %b addr %0h exp 1/0", imem_req, imem_addr); end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_illegal();
        test_reset_mid_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
